// File: rtl/vga_sync.sv
// 640x480@60 VGA pixel-timing generator: row/column counters plus registered syncs.
// Optional macro VGA_SYNC_PIXDIV_EN: divide clk by two to make a pixel enable.
module vga_sync #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] r,
    output logic [9:0] c,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] r_q, r_d;
    logic [9:0] c_q, c_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_end_q, frame_end_d;
    logic       tick_next;

`ifdef VGA_SYNC_PIXDIV_EN
    logic phase_q, phase_d;

    // Phase flop toggles every clk; its next value is next cycle's pixel enable.
    always_comb begin
        phase_d   = ~phase_q;
        tick_next = phase_d;
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign pix_tick = phase_q;
`else
    assign tick_next = 1'b1;
    assign pix_tick  = 1'b1;
`endif

    // Counter advance; syncs and frame_end are decoded from the next counter values
    // so that every registered output lines up with the r/c shown in the same cycle.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (pix_tick) begin
            if (c_q == H_LAST) begin
                c_d = 10'd0;
                if (r_q == V_LAST) begin
                    r_d = 10'd0;
                end else begin
                    r_d = r_q + 10'd1;
                end
            end else begin
                c_d = c_q + 10'd1;
            end
        end else begin
            c_d = c_q;
        end
        hsync_d     = !((c_d >= HS_FIRST) && (c_d <= HS_LAST));
        vsync_d     = !((r_d >= VS_FIRST) && (r_d <= VS_LAST));
        video_on_d  = (r_d < V_VIS) && (c_d < H_VIS);
        frame_end_d = tick_next && (r_d == V_LAST) && (c_d == H_LAST);
    end

    // Output/counter registers; reset wins over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= 10'd0;
            c_q         <= 10'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign r         = r_q;
    assign c         = c_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: a default-timing instance and a shrunken-timing
// instance are checked every cycle against an arithmetic pixel-index model.
module tb_vga_sync;

    logic       clk;
    logic       reset;

    logic       pt_s, hs_s, vs_s, vo_s, fe_s;
    logic [9:0] r_s, c_s;
    logic       pt_m, hs_m, vs_m, vo_m, fe_m;
    logic [9:0] r_m, c_m;

    int n_tests;
    int n_fail;
    int k;

    vga_sync dut_std (
        .clk(clk), .reset(reset), .pix_tick(pt_s), .r(r_s), .c(c_s),
        .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .frame_end(fe_s)
    );

    vga_sync #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
        .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
    ) dut_small (
        .clk(clk), .reset(reset), .pix_tick(pt_m), .r(r_m), .c(c_m),
        .hsync(hs_m), .vsync(vs_m), .video_on(vo_m), .frame_end(fe_m)
    );

    wire [24:0] obs_std   = {pt_s, r_s, c_s, hs_s, vs_s, vo_s, fe_s};
    wire [24:0] obs_small = {pt_m, r_m, c_m, hs_m, vs_m, vo_m, fe_m};

    localparam int SM_HT = 58;
    localparam int SM_VT = 40;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel ticks completed before clock k after reset.
    function automatic int tk(input int kk);
`ifdef VGA_SYNC_PIXDIV_EN
        return kk / 2;
`else
        return kk;
`endif
    endfunction

    // Expected outputs for the k-th cycle after reset, from the raster rules.
    function automatic logic [24:0] model(input int kk, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb);
        int ht, vt, n, rr, cc;
        logic pt, hsn, vsn, vo, fe;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
`ifdef VGA_SYNC_PIXDIV_EN
        pt = (kk % 2) == 1;
`else
        pt = 1'b1;
`endif
        n   = tk(kk) % (ht * vt);
        rr  = n / ht;
        cc  = n % ht;
        hsn = !(cc >= hv + hf && cc < hv + hf + hs);
        vsn = !(rr >= vv + vf && rr < vv + vf + vs);
        vo  = (rr < vv) && (cc < hv);
        fe  = pt && (rr == vt - 1) && (cc == ht - 1);
        return {pt, 10'(rr), 10'(cc), hsn, vsn, vo, fe};
    endfunction

    function automatic logic [24:0] exp_std(input int kk);
        return model(kk, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] exp_small(input int kk);
        return model(kk, 40, 4, 8, 6, 30, 3, 2, 5);
    endfunction

    // One clock: k counts edges since the last edge that saw reset high.
    task automatic step();
        @(posedge clk);
        if (reset) k = 0;
        else k = k + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int hold;
        reset = 1'b1;
        hold = $urandom_range(9, 5);
        for (int i = 0; i < hold; i++) begin
            step();
            n_tests++;
            if (obs_std !== exp_std(0)) begin
                n_fail++;
                $display("FAIL reset_hold_std got %h expected %h", obs_std, exp_std(0));
            end
            n_tests++;
            if (obs_small !== exp_small(0)) begin
                n_fail++;
                $display("FAIL reset_hold_small got %h expected %h", obs_small, exp_small(0));
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4 && tk(k) < 1; i++) begin
            step();
            n_tests++;
            if (obs_std !== exp_std(k)) begin
                n_fail++;
                $display("FAIL first_tick k=%0d got %h expected %h", k, obs_std, exp_std(k));
            end
        end
        n_tests++;
        if (r_s !== 10'd0 || c_s !== 10'd1 || hs_s !== 1'b1 || vs_s !== 1'b1 || vo_s !== 1'b1) begin
            n_fail++;
            $display("FAIL after_one_tick got r=%0d c=%0d hs=%b vs=%b vo=%b expected r=0 c=1 1 1 1",
                     r_s, c_s, hs_s, vs_s, vo_s);
        end
    endtask

    task automatic test_row_wrap();
        int target;
        target = 800 + $urandom_range(6, 0);
        for (int i = 0; i < 4000 && tk(k) < target; i++) begin
            step();
            n_tests++;
            if (obs_std !== exp_std(k)) begin
                n_fail++;
                $display("FAIL row0_scan k=%0d got %h expected %h", k, obs_std, exp_std(k));
            end
            if (tk(k) == 800) begin
                n_tests++;
                if (r_s !== 10'd1 || c_s !== 10'd0 || vo_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL row_wrap got r=%0d c=%0d vo=%b expected r=1 c=0 vo=1", r_s, c_s, vo_s);
                end
            end
        end
        n_tests++;
        if (tk(k) < target) begin
            n_fail++;
            $display("FAIL row_wrap_timeout ticks=%0d required %0d", tk(k), target);
        end
    endtask

    task automatic test_hsync();
        int fall_c, rise_c, width;
        logic prev_hs;
        fall_c = -1; rise_c = -1; width = 0;
        prev_hs = hs_s;
        for (int i = 0; i < 20000 && tk(k) < 11 * 800; i++) begin
            step();
            n_tests++;
            if (obs_std !== exp_std(k)) begin
                n_fail++;
                $display("FAIL row_scan k=%0d got %h expected %h", k, obs_std, exp_std(k));
            end
            if (r_s == 10'd10) begin
                if (prev_hs && !hs_s) fall_c = int'(c_s);
                if (!prev_hs && hs_s) rise_c = int'(c_s);
                if (!hs_s && pt_s) width++;
            end
            prev_hs = hs_s;
        end
        n_tests++;
        if (fall_c != 656) begin
            n_fail++;
            $display("FAIL hsync_fall got c=%0d expected 656", fall_c);
        end
        n_tests++;
        if (rise_c != 752) begin
            n_fail++;
            $display("FAIL hsync_rise got c=%0d expected 752", rise_c);
        end
        n_tests++;
        if (width != 96) begin
            n_fail++;
            $display("FAIL hsync_width got %0d expected 96", width);
        end
    endtask

    task automatic test_frame();
        int pulses[$];
        int vs_low;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vs_low = 0;
        for (int i = 0; i < 20000 && tk(k) < 2 * SM_HT * SM_VT + 3; i++) begin
            step();
            n_tests++;
            if (obs_small !== exp_small(k)) begin
                n_fail++;
                $display("FAIL frame_scan k=%0d got %h expected %h", k, obs_small, exp_small(k));
            end
            if (fe_m) pulses.push_back(tk(k));
            if (!vs_m && pt_m && tk(k) < SM_HT * SM_VT) vs_low++;
        end
        n_tests++;
        if (pulses.size() != 2) begin
            n_fail++;
            $display("FAIL frame_end_count got %0d expected 2", pulses.size());
        end else begin
            n_tests++;
            if (pulses[0] != SM_HT * SM_VT - 1) begin
                n_fail++;
                $display("FAIL frame_end_first got tick %0d expected %0d", pulses[0], SM_HT * SM_VT - 1);
            end
            n_tests++;
            if (pulses[1] - pulses[0] != SM_HT * SM_VT) begin
                n_fail++;
                $display("FAIL frame_end_period got %0d expected %0d", pulses[1] - pulses[0], SM_HT * SM_VT);
            end
        end
        n_tests++;
        if (vs_low != 2 * SM_HT) begin
            n_fail++;
            $display("FAIL vsync_low_ticks got %0d expected %0d", vs_low, 2 * SM_HT);
        end
    endtask

    task automatic test_midreset();
        int target, fe_seen;
        for (int rep = 0; rep < 3; rep++) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            target = $urandom_range(2200, 200);
            fe_seen = 0;
            for (int i = 0; i < 6000 && tk(k) < target; i++) begin
                step();
                n_tests++;
                if (obs_small !== exp_small(k)) begin
                    n_fail++;
                    $display("FAIL pre_reset k=%0d got %h expected %h", k, obs_small, exp_small(k));
                end
                if (fe_m) fe_seen++;
            end
            reset = 1'b1;
            step();
            reset = 1'b0;
            n_tests++;
            if (obs_small !== exp_small(0) || obs_std !== exp_std(0)) begin
                n_fail++;
                $display("FAIL mid_reset got %h/%h expected %h/%h",
                         obs_small, obs_std, exp_small(0), exp_std(0));
            end
            n_tests++;
            if (fe_seen != 0) begin
                n_fail++;
                $display("FAIL mid_frame_end got %0d pulses expected 0", fe_seen);
            end
            for (int i = 0; i < int'($urandom_range(80, 20)); i++) begin
                step();
                n_tests++;
                if (obs_small !== exp_small(k) || obs_std !== exp_std(k)) begin
                    n_fail++;
                    $display("FAIL resume k=%0d got %h/%h expected %h/%h",
                             k, obs_small, obs_std, exp_small(k), exp_std(k));
                end
            end
        end
    endtask

    task automatic test_ten_columns();
        int clocks;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clocks = 0;
        for (int i = 0; i < 40 && c_s != 10'd10; i++) begin
            step();
            clocks++;
        end
        n_tests++;
`ifdef VGA_SYNC_PIXDIV_EN
        if (clocks != 20) begin
            n_fail++;
            $display("FAIL c10_latency got %0d clocks expected 20", clocks);
        end
`else
        if (clocks != 10) begin
            n_fail++;
            $display("FAIL c10_latency got %0d clocks expected 10", clocks);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        k       = 0;
        reset   = 1'b1;
        test_reset();
        test_row_wrap();
        test_hsync();
        test_frame();
        test_midreset();
        test_ten_columns();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
